freq_div_prog: RTL and testbench
================================

Name: freq_div_prog

Overview:
- Parametrised, run-time programmable successor to the fixed-preset 1 Hz divider.
- Produces a 50%-duty square clock enable/strobe from clk_50mhz, with the half-period set by a register.
- Divisor changes use a load/ack handshake and take effect only at a period boundary, so no truncated or glitched periods occur.
- Feeds display scan, counters and LED blink logic that currently hard-code preset divisors.

Parameters:
CNT_W, 32, width of the counter and of div_half; must satisfy 2^CNT_W > DEFAULT_HALF.
DEFAULT_HALF, 25000000, half-period in clk_50mhz cycles after reset (1 Hz at 50 MHz).

Ports:
clk_50mhz  input  1  system clock, all logic on its rising edge
rst  input  1  synchronous reset, active-high
en  input  1  run enable; low freezes the divider
div_half  input  CNT_W  requested half-period in cycles
div_load  input  1  1-cycle strobe; samples div_half
div_ack  output  1  1-cycle pulse, the cycle after div_load is sampled
pending  output  1  high while a loaded value waits for a period boundary
clk_out  output  1  divided square wave, period 2*act_half cycles
tick  output  1  1-cycle pulse coincident with each 0->1 transition of clk_out

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything, including mid-period): cnt=0, clk_out=0, tick=0, div_ack=0, pending=0, pend_half=0, act_half=DEFAULT_HALF.
- Clamp rule: a div_half of 0 is stored as 1. No other arithmetic is applied. The counter compares against act_half-1 at CNT_W bits.
- Run (en=1):
  - If cnt != act_half-1, then cnt<=cnt+1.
  - If cnt == act_half-1, then cnt<=0 and clk_out toggles. This is a half boundary.
- Period boundary: a half boundary where clk_out goes 1->0. Only there:
  - if pending=1, then act_half<=pend_half and pending<=0.
- tick: registered, equals 1 exactly in the cycle clk_out first reads 1; otherwise 0.
- Load while en=1 (div_load=1):
  - Normally pend_half<=clamp(div_half) and pending<=1.
  - If the same cycle is a period boundary, act_half<=clamp(div_half) directly and pending stays 0. The new load wins over any older pending value.
  - A load while already pending overwrites pend_half. Last value wins.
- Load while en=0: act_half<=clamp(div_half) immediately, cnt<=0, clk_out<=0, pending<=0.
- div_ack: always pulses high for one cycle, the cycle after any accepted div_load. Every div_load is accepted.
- Hold (en=0): cnt, clk_out and act_half hold; tick=0.
- On re-enable, counting resumes from the held cnt with no extra cycle.
- Output period with act_half=H: clk_out high H cycles, low H cycles. Tick spacing is exactly 2H cycles in steady state.
- With H=1, clk_out toggles every cycle and tick pulses every 2 cycles.

Optional Feature:
- Macro FREQ_SYNC_EN.
- When defined:
  - Adds port sync_in (input, 1): external phase-align request, assumed synchronous to clk_50mhz.
  - One register stage detects its rising edge.
  - In the cycle after detection (en=1): cnt<=0, clk_out<=1, tick=1.
  - Any pending value is applied to act_half at this point, as if at a period boundary.
  - Sync and rst in the same cycle: rst wins.
  - Sync while en=0: ignored.
- When undefined: sync_in and its edge register do not exist. Behaviour is exactly as above.

Test Plan:
- DEFAULT_HALF=4, en=1 after reset: clk_out low 4 cycles / high 4; first tick at cycle 4; ticks every 8 cycles; pending=0.
- Load div_half=2 at cycle 10 (mid high phase): div_ack at cycle 11; pending=1 until the 1->0 edge at cycle 16; then period 4, next tick at cycle 18.
- Load div_half=0: stored as 1; after the boundary, clk_out toggles every cycle and tick every 2 cycles.
- Two loads (6 then 3) before a boundary: two div_ack pulses; act_half=3 after the boundary; 6 is never applied.
- en=0 for 5 cycles at cnt=2: clk_out/cnt frozen, tick=0; resumes at cnt=3.
- Load 7 with en=0: immediate act_half=7, clk_out=0, pending=0.
- rst=1 mid high phase with pending=1: next cycle clk_out=0, pending=0, act_half=DEFAULT_HALF.
- FREQ_SYNC_EN: sync_in rises at cnt=1 of a low phase: two cycles later clk_out=1 and tick=1; high phase lasts act_half cycles.

Source files
------------

// File: rtl/freq_div_prog.sv
// Programmable 50%-duty clock divider with a load/ack handshake; new half-periods apply at period boundaries.
// Optional phase-align input sync_in is built only when FREQ_SYNC_EN is defined.
module freq_div_prog #(
   parameter int          CNT_W        = 32,
   parameter int unsigned DEFAULT_HALF = 25000000
) (
   input  logic             clk_50mhz,
   input  logic             rst,
   input  logic             en,
`ifdef FREQ_SYNC_EN
   input  logic             sync_in,
`endif
   input  logic [CNT_W-1:0] div_half,
   input  logic             div_load,
   output logic             div_ack,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] act_half;
   logic [CNT_W-1:0] pend_half;
   logic [CNT_W-1:0] load_val;
   logic             half_end;
   logic             boundary;
   logic             align;

   assign load_val = (div_half == '0) ? ONE : div_half;
   assign half_end = (cnt == act_half - ONE);

`ifdef FREQ_SYNC_EN
   logic sync_prev;
   logic sync_fire;

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         sync_prev <= 1'b0;
         sync_fire <= 1'b0;
      end else begin
         sync_prev <= sync_in;
         sync_fire <= sync_in & ~sync_prev;
      end
   end

   assign align = sync_fire;
`else
   assign align = 1'b0;
`endif

   // Phase alignment counts as a period boundary so pending values land with it.
   assign boundary = (half_end && clk_out) || align;

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         cnt       <= '0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         div_ack   <= 1'b0;
         pending   <= 1'b0;
         pend_half <= '0;
         act_half  <= DEF_HALF;
      end else begin
         div_ack <= div_load;
         tick    <= 1'b0;
         if (en) begin
            if (align) begin
               cnt     <= '0;
               clk_out <= 1'b1;
               tick    <= 1'b1;
            end else if (half_end) begin
               cnt     <= '0;
               clk_out <= ~clk_out;
               tick    <= ~clk_out;
            end else begin
               cnt <= cnt + ONE;
            end

            // A load landing on a boundary supersedes any older pending value.
            if (div_load && boundary) begin
               act_half <= load_val;
               pending  <= 1'b0;
            end else begin
               if (boundary && pending) begin
                  act_half <= pend_half;
                  pending  <= 1'b0;
               end
               if (div_load) begin
                  pend_half <= load_val;
                  pending   <= 1'b1;
               end
            end
         end else if (div_load) begin
            act_half <= load_val;
            cnt      <= '0;
            clk_out  <= 1'b0;
            pending  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_freq_div_prog.sv
// Scoreboard bench for freq_div_prog: expected tick/ack cycles are queued by the driver and popped by a monitor.
module tb_freq_div_prog;

   localparam int CNT_W = 8;
   localparam int DEF   = 4;

   logic             clk_50mhz = 1'b0;
   logic             rst       = 1'b1;
   logic             en        = 1'b0;
   logic [CNT_W-1:0] div_half  = '0;
   logic             div_load  = 1'b0;
   logic             div_ack;
   logic             pending;
   logic             clk_out;
   logic             tick;

   freq_div_prog #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .en        (en),
`ifdef FREQ_SYNC_EN
      .sync_in   (1'b0),
`endif
      .div_half  (div_half),
      .div_load  (div_load),
      .div_ack   (div_ack),
      .pending   (pending),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   // Cycle index: 0 is the first cycle after the last reset edge.
   int cyc = 0;
   always @(posedge clk_50mhz) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int q_tick[$];
   int q_ack[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk_50mhz) begin
      int e;
      if (tick === 1'b1) begin
         if (q_tick.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_unexpected: actual tick at cycle %0d, required none", cyc);
         end else begin
            e = q_tick.pop_front();
            chk("tick_cycle", cyc, e);
         end
      end
      if (div_ack === 1'b1) begin
         if (q_ack.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_unexpected: actual ack at cycle %0d, required none", cyc);
         end else begin
            e = q_ack.pop_front();
            chk("ack_cycle", cyc, e);
         end
      end
   end

   task automatic at(input int n);
      int guard = 0;
      do begin
         @(negedge clk_50mhz);
         guard++;
      end while (cyc != n && guard < 300);
      if (cyc != n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_cycle: actual cycle %0d, required %0d", cyc, n);
      end
   endtask

   task automatic load(input logic [CNT_W-1:0] v);
      div_half = v;
      div_load = 1'b1;
   endtask

   initial begin
      en  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk_50mhz);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ack", div_ack, 0);
      chk("rst_pending", pending, 0);
      rst = 1'b0;

      // Segment A: default half 4, then load 2 mid-period, then reset while pending.
      q_tick.push_back(4);
      q_tick.push_back(12);
      at(10);
      load(8'd2);
      q_ack.push_back(11);
      q_tick.push_back(18);
      q_tick.push_back(22);
      q_tick.push_back(26);
      at(11);
      div_load = 1'b0;
      chk("a_pending_11", pending, 1);
      at(15);
      chk("a_pending_15", pending, 1);
      chk("a_clk_15", clk_out, 1);
      at(16);
      chk("a_pending_16", pending, 0);
      chk("a_clk_16", clk_out, 0);
      at(17);
      chk("a_clk_17", clk_out, 0);
      at(18);
      chk("a_clk_18", clk_out, 1);
      at(24);
      load(8'd5);
      q_ack.push_back(25);
      at(25);
      div_load = 1'b0;
      at(26);
      chk("a_clk_26", clk_out, 1);
      chk("a_pending_26", pending, 1);
      rst = 1'b1;
      @(negedge clk_50mhz);
      chk("a_rst_clk_out", clk_out, 0);
      chk("a_rst_pending", pending, 0);
      chk("a_rst_tick", tick, 0);
      rst = 1'b0;

      // Segment B: act_half back to 4; double load, boundary load of 0, hold, load while disabled.
      q_tick.push_back(4);
      at(5);
      load(8'd6);
      q_ack.push_back(6);
      at(6);
      load(8'd3);
      q_ack.push_back(7);
      chk("b_pending_6", pending, 1);
      at(7);
      div_load = 1'b0;
      at(8);
      chk("b_pending_8", pending, 0);
      q_tick.push_back(11);
      q_tick.push_back(17);
      at(10);
      chk("b_clk_10", clk_out, 0);
      at(11);
      chk("b_clk_11", clk_out, 1);
      at(19);
      load(8'd0);
      q_ack.push_back(20);
      for (int t = 21; t <= 31; t += 2) q_tick.push_back(t);
      at(20);
      div_load = 1'b0;
      chk("b_pending_20", pending, 0);
      chk("b_clk_20", clk_out, 0);
      at(22);
      chk("b_clk_22", clk_out, 0);
      at(30);
      load(8'd4);
      q_ack.push_back(31);
      at(31);
      div_load = 1'b0;
      chk("b_pending_31", pending, 1);
      at(32);
      chk("b_pending_32", pending, 0);
      at(34);
      en = 1'b0;
      at(36);
      chk("b_hold_tick_36", tick, 0);
      at(37);
      chk("b_hold_clk_37", clk_out, 0);
      at(39);
      en = 1'b1;
      q_tick.push_back(41);
      at(43);
      en = 1'b0;
      load(8'd7);
      q_ack.push_back(44);
      at(44);
      div_load = 1'b0;
      en = 1'b1;
      chk("b_dis_clk_44", clk_out, 0);
      chk("b_dis_pending_44", pending, 0);
      q_tick.push_back(51);
      q_tick.push_back(65);
      at(50);
      chk("b_clk_50", clk_out, 0);
      at(70);
      chk("tick_queue_left", q_tick.size(), 0);
      chk("ack_queue_left", q_ack.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
